// File: rtl/contador_sequenciador.sv
// Sequencing controller for a W-bit up/down loadable counter.
// A command (start, target, direction, pass count) is accepted over a
// valid/ready handshake. The controller then drives the counter's
// Load/UpDown/Entrada inputs and watches its Saida output to run the
// requested passes. Whenever it is not counting, it freezes the counter
// by reloading the counter's own value.
//
// Handshake: a command transfers on a rising edge where CmdValid and
// CmdReady are both 1. CmdReady is 1 only in IDLE. A command presented
// while CmdReady=0 is dropped, not queued.
module contador_sequenciador #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         CmdValid,
    output logic         CmdReady,
    input  logic [W-1:0] Partida,
    input  logic [W-1:0] Alvo,
    input  logic         Direcao,
    input  logic [W-1:0] Passes,
    input  logic         Abortar,
    input  logic [W-1:0] Saida,
    output logic         Load,
    output logic         UpDown,
    output logic [W-1:0] Entrada,
    output logic         Ocupado,
    output logic         Fim,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t       state;
    state_t       state_next;
    logic [W-1:0] r_partida;
    logic [W-1:0] r_alvo;
    logic         r_dir;
    logic [W-1:0] r_rest;
    logic [W-1:0] r_hold;
    logic         hit;
    logic         abort_ok;

    // The counter has reached the target of the current pass.
    assign hit       = (Saida == r_alvo);
    // An abort is honoured only while a command is actually running.
    assign abort_ok  = Abortar && ((state == ST_LOAD) || (state == ST_COUNT));
    assign dbg_state = state;

    // Next-state and counter-drive decode. While frozen, the counter is
    // reloaded with its own value so that it holds.
    always_comb begin
        state_next = state;
        CmdReady   = 1'b0;
        Load       = 1'b0;
        UpDown     = r_dir;
        Entrada    = r_alvo;
        Ocupado    = 1'b0;
        Fim        = 1'b0;
        case (state)
            ST_IDLE: begin
                CmdReady = 1'b1;
                Load     = 1'b1;
                Entrada  = r_hold;
                UpDown   = 1'b1;
                if (CmdValid) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                Load    = 1'b1;
                Entrada = r_partida;
                Ocupado = 1'b1;
                if (Abortar) begin
                    Entrada    = Saida;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                Ocupado = 1'b1;
                Load    = hit;
                Entrada = r_alvo;
                if (Abortar) begin
                    Load       = 1'b1;
                    Entrada    = Saida;
                    state_next = ST_IDLE;
                end else if (hit) begin
                    state_next = (r_rest > ONE) ? ST_LOAD : ST_DONE;
                end
            end
            ST_DONE: begin
                Fim        = 1'b1;
                Load       = 1'b1;
                Entrada    = r_hold;
                Ocupado    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and latched command fields.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            r_partida <= '0;
            r_alvo    <= '0;
            r_dir     <= 1'b0;
            r_rest    <= '0;
            r_hold    <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && CmdValid) begin
                r_partida <= Partida;
                r_alvo    <= Alvo;
                r_dir     <= Direcao;
                r_rest    <= (Passes == '0) ? ONE : Passes;
            end
            if (abort_ok) begin
                r_hold <= Saida;
            end else if (state == ST_COUNT && hit) begin
                if (r_rest > ONE) r_rest <= r_rest - ONE;
                else              r_hold <= r_alvo;
            end
        end
    end

endmodule

// File: tb/tb_contador_sequenciador.sv
// Directed bench for contador_sequenciador. It contains a behavioural
// model of the loadable up/down counter that closes the loop on
// Saida/Load/UpDown/Entrada.
module tb_contador_sequenciador;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] partida;
    logic [W-1:0] alvo;
    logic         direcao;
    logic [W-1:0] passes;
    logic         abortar;
    logic [W-1:0] saida = '0;
    logic         load;
    logic         up_down;
    logic [W-1:0] entrada;
    logic         ocupado;
    logic         fim;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] partida;
        logic [W-1:0] alvo;
        logic         dir;
        logic [W-1:0] passes;
        int           exp_fim;   // cycle of Fim, counted from acceptance edge
        int           exp_hits;  // cycles (from first COUNT on) with Saida==partida
    } vec_t;

    vec_t tbl[5];

    contador_sequenciador #(.W(W)) dut (
        .Clock     (clk),
        .Reset     (rst_n),
        .CmdValid  (cmd_valid),
        .CmdReady  (cmd_ready),
        .Partida   (partida),
        .Alvo      (alvo),
        .Direcao   (direcao),
        .Passes    (passes),
        .Abortar   (abortar),
        .Saida     (saida),
        .Load      (load),
        .UpDown    (up_down),
        .Entrada   (entrada),
        .Ocupado   (ocupado),
        .Fim       (fim),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Counter being sequenced: load on Load, otherwise step by UpDown.
    always @(posedge clk) begin
        if (load)         saida <= entrada;
        else if (up_down) saida <= saida + 1'b1;
        else              saida <= saida - 1'b1;
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (input phase).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        partida = W'($urandom_range(0, 15));
        alvo    = W'($urandom_range(0, 15));
        direcao = 1'($urandom_range(0, 1));
        passes  = W'($urandom_range(0, 15));
    endtask

    // Run one table command from IDLE and check its timing and final freeze.
    task automatic run_cmd(input vec_t v, input int idx);
        int fim_k;
        int fims;
        int hits;
        int frozen;
        string tag;
        tag = $sformatf("row%0d", idx);
        partida   = v.partida;
        alvo      = v.alvo;
        direcao   = v.dir;
        passes    = v.passes;
        cmd_valid = 1'b1;
        #1;
        chk({tag, "_ready_idle"}, int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        scramble_inputs();
        fim_k = 0;
        fims  = 0;
        hits  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 2) cmd_valid = 1'b1;
            #1;
            if (k == 1) begin
                chk({tag, "_load_entrada"}, int'({load, entrada}), int'({1'b1, v.partida}));
                chk({tag, "_load_busy"}, int'(ocupado), 1);
            end
            if (k == 2) chk({tag, "_ready_busy"}, int'(cmd_ready), 0);
            if (k >= 2 && saida == v.partida) hits++;
            if (fim) begin
                fims++;
                fim_k = k;
                break;
            end
            tick();
            cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk({tag, "_fim_cycle"}, fim_k, v.exp_fim);
        chk({tag, "_start_hits"}, hits, v.exp_hits);
        tick();
        #1;
        chk({tag, "_ready_after"}, int'({cmd_ready, ocupado, fim}), 3'b100);
        frozen = 1;
        for (int k = 0; k < 5; k++) begin
            if (saida != v.alvo || fim) frozen = 0;
            tick();
            #1;
        end
        chk({tag, "_freeze"}, frozen, 1);
    endtask

    initial begin
        int k;
        int ok;
        int fim_seen;

        tbl[0] = '{partida: 4'd3,  alvo: 4'd9,  dir: 1'b1, passes: 4'd1, exp_fim: 9,  exp_hits: 1};
        tbl[1] = '{partida: 4'd14, alvo: 4'd2,  dir: 1'b1, passes: 4'd2, exp_fim: 13, exp_hits: 2};
        tbl[2] = '{partida: 4'd5,  alvo: 4'd5,  dir: 1'b0, passes: 4'd0, exp_fim: 3,  exp_hits: 2};
        tbl[3] = '{partida: 4'd10, alvo: 4'd7,  dir: 1'b0, passes: 4'd3, exp_fim: 16, exp_hits: 3};
        tbl[4] = '{partida: 4'd2,  alvo: 4'd12, dir: 1'b0, passes: 4'd1, exp_fim: 9,  exp_hits: 1};

        // Reset, with a command held during reset that must not be taken.
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        abortar   = 1'b0;
        partida   = 4'd7;
        alvo      = 4'd8;
        direcao   = 1'b1;
        passes    = 4'd1;
        tick();
        tick();
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("rst_ready",   int'(cmd_ready), 1);
        chk("rst_load",    int'(load), 1);
        chk("rst_entrada", int'(entrada), 0);
        chk("rst_updown",  int'(up_down), 1);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_fim",     int'(fim), 0);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            if (saida != 0 || fim || !cmd_ready) ok = 0;
        end
        chk("rst_hold_zero", ok, 1);

        // Table-driven commands.
        for (int i = 0; i < 5; i++) begin
            tick();
            run_cmd(tbl[i], i);
        end

        // Abort while counting up 0..15 at Saida=6.
        tick();
        partida   = 4'd0;
        alvo      = 4'd15;
        direcao   = 1'b1;
        passes    = 4'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        k = 1;
        fim_seen = 0;
        for (k = 1; k <= 30; k++) begin
            if (k == 4) begin
                cmd_valid = 1'b1;
                partida   = 4'd1;
                alvo      = 4'd2;
            end
            #1;
            if (fim) fim_seen = 1;
            if (k == 4) chk("abort_ready_busy", int'(cmd_ready), 0);
            if (saida == 4'd6 && k >= 2) break;
            tick();
            cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("abort_reach6_cycle", k, 8);
        abortar = 1'b1;
        #1;
        chk("abort_load", int'({load, entrada}), int'({1'b1, 4'd6}));
        tick();
        abortar = 1'b0;
        #1;
        chk("abort_idle", int'({cmd_ready, ocupado, fim}), 3'b100);
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (saida != 4'd6) ok = 0;
            if (fim) fim_seen = 1;
        end
        chk("abort_freeze6", ok, 1);
        chk("abort_no_fim", fim_seen, 0);

        // Synchronous reset mid-pass, counting down, at Saida=4.
        tick();
        partida   = 4'd9;
        alvo      = 4'd1;
        direcao   = 1'b0;
        passes    = 4'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        fim_seen = 0;
        for (k = 1; k <= 30; k++) begin
            #1;
            if (fim) fim_seen = 1;
            if (saida == 4'd4 && k >= 2) break;
            tick();
        end
        chk("rstmid_reach4_cycle", k, 7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstmid_idle", int'({cmd_ready, load, ocupado, fim}), 4'b1100);
        chk("rstmid_entrada", int'(entrada), 0);
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (saida != 0) ok = 0;
            if (fim) fim_seen = 1;
        end
        chk("rstmid_hold_zero", ok, 1);
        chk("rstmid_no_fim", fim_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
